intersection_traffic_model: RTL and testbench
=============================================

Name: intersection_traffic_model

Overview:
Vehicle-side model of a two-road intersection: the opposite end of the traffic light controller interface. Consumes the controller's light outputs (main_road, side_road, main_turn_left, side_turn_left), queues arriving vehicles per lane, and releases them at a paced rate while their light permits. Drives main_sensor/side_sensor back to the controller and flags illegal light combinations. Used in closed-loop simulation and on-board demo against the controller.

Parameters:
QUEUE_W, 5, width of each lane queue counter (max depth 2**QUEUE_W-1)
DEPART_CYCLES, 4, cycles of continuous permission needed per vehicle departure (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
main_arrive  in  1  one vehicle arrives, main through lane (per-cycle pulse)
main_left_arrive  in  1  one vehicle arrives, main left-turn lane
side_arrive  in  1  one vehicle arrives, side through lane
side_left_arrive  in  1  one vehicle arrives, side left-turn lane
main_road  in  3  main light: 3'b100 red, 3'b010 yellow, 3'b001 green
side_road  in  3  side light, same encoding
main_turn_left  in  1  main left arrow active
side_turn_left  in  1  side left arrow active
main_sensor  out  1  main road has waiting vehicles
side_sensor  out  1  side road has waiting vehicles
main_q  out  QUEUE_W  main through queue count
main_left_q  out  QUEUE_W  main left queue count
side_q  out  QUEUE_W  side through queue count
side_left_q  out  QUEUE_W  side left queue count
overflow  out  1  sticky: an arrival was dropped on a full queue
fault  out  1  sticky: illegal light combination seen
departed_total  out  16  total departures, wraps

Behaviour:
- One clock, synchronous active-high rst; rst overrides all other inputs in the same cycle, including mid-departure.
- Reset values: all four queues 0, all pacing counters 0, overflow 0, fault 0, departed_total 0, both sensors 0.
- illegal_now (combinational): either road code not in {100,010,001}; OR main_road!=100 AND side_road!=100; OR main_turn_left AND side_turn_left.
- fault <= 1 on any edge where illegal_now; cleared only by rst.
- Per-lane permission (go): main through = main_road==001; main left = main_turn_left; side likewise. All go qualified by !fault && !illegal_now. Yellow and red grant nothing.
- Each lane has a pacing counter pc (width clog2(DEPART_CYCLES), min 1 bit). On each edge: if go && q!=0: if pc==DEPART_CYCLES-1 then depart (pc<=0) else pc<=pc+1. Otherwise pc<=0. Permission held from edge k yields departures at edges k+DEPART_CYCLES-1, k+2*DEPART_CYCLES-1, ...; any gap in go restarts the full count.
- Queue update per lane: arrival and departure in the same edge -> q unchanged. Arrival only -> q+1, unless q is all-ones: q holds, overflow<=1. Departure only -> q-1 (never below 0; departure requires q!=0).
- departed_total <= departed_total + number of lanes departing this edge (0..4), modulo 2**16.
- main_sensor = (main_q!=0)|(main_left_q!=0); side_sensor likewise. Both derived combinationally from registered queues (glitch-free); an arrival is visible on the sensor one edge after it is sampled.
- Arrivals are still counted while fault is set; only departures stop.

Test Plan:
- Reset: rst high 2 cycles with all arrive inputs high -> all queues 0, sensors 0, overflow 0, fault 0, departed_total 0.
- Paced release: 3 main_arrive pulses, main red/side green -> main_q=3, main_sensor=1; then main green/side red held from edge k -> main_q=2 at k+3, 1 at k+7, 0 at k+11; main_sensor falls at k+11; departed_total=3.
- Interrupted green: main_q=2, green for 3 cycles then yellow -> main_q stays 2, pc cleared; green again -> first departure exactly 4 edges later.
- Simultaneous: arrival pulse on the departure edge -> main_q unchanged, departed_total+1; left lane releases independently on main_turn_left with through lane red.
- Saturation: 33 side_arrive pulses, side red -> side_q=31, overflow=1, stays 1 after queue drains.
- Conflict: main_road=001 and side_road=001 on one cycle with queues non-empty -> no departure that edge, fault=1 next, no further departures, arrivals still increment; rst clears fault. Illegal code 3'b011 also sets fault.

Source files
------------

// File: rtl/intersection_traffic_model.sv
// -----------------------------------------------------------------------------
// intersection_traffic_model
//
// Vehicle-side model of a two-road intersection. It watches the light outputs
// of a traffic light controller, keeps a vehicle count for each of four lanes
// (main through, main left, side through, side left) and releases vehicles
// at a paced rate while the lane's light permits. It reports waiting traffic
// back to the controller and flags illegal light combinations.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   *_arrive               one-cycle pulse = one vehicle joins that lane
//   main_road, side_road   light codes: 100 red, 010 yellow, 001 green
//   main/side_turn_left    left-turn arrow active
//   main/side_sensor       road has waiting vehicles (from registered queues)
//   *_q                    per-lane queue counts
//   overflow               sticky: an arrival was dropped on a full queue
//   fault                  sticky: illegal light combination was observed
//   departed_total         total departures, wraps at 2**16
// -----------------------------------------------------------------------------
module intersection_traffic_model #(
   parameter int QUEUE_W       = 5,
   parameter int DEPART_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               main_arrive,
   input  logic               main_left_arrive,
   input  logic               side_arrive,
   input  logic               side_left_arrive,
   input  logic [2:0]         main_road,
   input  logic [2:0]         side_road,
   input  logic               main_turn_left,
   input  logic               side_turn_left,
   output logic               main_sensor,
   output logic               side_sensor,
   output logic [QUEUE_W-1:0] main_q,
   output logic [QUEUE_W-1:0] main_left_q,
   output logic [QUEUE_W-1:0] side_q,
   output logic [QUEUE_W-1:0] side_left_q,
   output logic               overflow,
   output logic               fault,
   output logic [15:0]        departed_total
);

   localparam int              PC_W    = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(DEPART_CYCLES - 1);

   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] YELLOW = 3'b010;
   localparam logic [2:0] GREEN  = 3'b001;

   // Lane index: 0 main through, 1 main left, 2 side through, 3 side left.
   logic [QUEUE_W-1:0] q_q  [4];
   logic [QUEUE_W-1:0] q_d  [4];
   logic [PC_W-1:0]    pc_q [4];
   logic [PC_W-1:0]    pc_d [4];
   logic               overflow_q, overflow_d;
   logic               fault_q, fault_d;
   logic [15:0]        total_q, total_d;

   logic       main_code_ok, side_code_ok, illegal_now;
   logic [3:0] arrive, go_raw, go, depart, ovf_hit;
   logic [2:0] dep_count;

   assign main_code_ok = (main_road == RED) || (main_road == YELLOW) || (main_road == GREEN);
   assign side_code_ok = (side_road == RED) || (side_road == YELLOW) || (side_road == GREEN);

   // Both roads non-red covers green/green and any yellow against a non-red road.
   assign illegal_now = !main_code_ok || !side_code_ok ||
                        ((main_road != RED) && (side_road != RED)) ||
                        (main_turn_left && side_turn_left);

   assign arrive = {side_left_arrive, side_arrive, main_left_arrive, main_arrive};
   assign go_raw = {side_turn_left, (side_road == GREEN), main_turn_left, (main_road == GREEN)};

   // Permission is withdrawn on the offending edge itself, not only once
   // the sticky fault has registered.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_go
         assign go[gi] = go_raw[gi] && !fault_q && !illegal_now;
      end
   endgenerate

   always_comb begin
      dep_count = 3'd0;
      for (int i = 0; i < 4; i++) begin
         depart[i]  = 1'b0;
         ovf_hit[i] = 1'b0;
         pc_d[i]    = '0;
         q_d[i]     = q_q[i];

         // Any cycle without permission (or with an empty lane) restarts pacing.
         if (go[i] && (q_q[i] != '0)) begin
            if (pc_q[i] == PC_LAST) begin
               depart[i] = 1'b1;
            end else begin
               pc_d[i] = pc_q[i] + PC_W'(1);
            end
         end

         if (arrive[i] && !depart[i]) begin
            if (&q_q[i]) begin
               ovf_hit[i] = 1'b1;
            end else begin
               q_d[i] = q_q[i] + QUEUE_W'(1);
            end
         end else if (depart[i] && !arrive[i]) begin
            q_d[i] = q_q[i] - QUEUE_W'(1);
         end

         dep_count = dep_count + {2'b00, depart[i]};
      end

      overflow_d = overflow_q | (|ovf_hit);
      fault_d    = fault_q | illegal_now;
      total_d    = total_q + 16'(dep_count);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            q_q[i]  <= '0;
            pc_q[i] <= '0;
         end
         overflow_q <= 1'b0;
         fault_q    <= 1'b0;
         total_q    <= 16'd0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            q_q[i]  <= q_d[i];
            pc_q[i] <= pc_d[i];
         end
         overflow_q <= overflow_d;
         fault_q    <= fault_d;
         total_q    <= total_d;
      end
   end

   assign main_q         = q_q[0];
   assign main_left_q    = q_q[1];
   assign side_q         = q_q[2];
   assign side_left_q    = q_q[3];
   assign main_sensor    = (q_q[0] != '0) || (q_q[1] != '0);
   assign side_sensor    = (q_q[2] != '0) || (q_q[3] != '0);
   assign overflow       = overflow_q;
   assign fault          = fault_q;
   assign departed_total = total_q;

endmodule

// File: tb/tb_intersection_traffic_model.sv
// -----------------------------------------------------------------------------
// tb_intersection_traffic_model
//
// Directed scenarios followed by a randomized run checked against a
// lane-count reference model (queue depth and "cycles of held permission"
// per lane, tracked as plain integers).
// -----------------------------------------------------------------------------
module tb_intersection_traffic_model;

   localparam int QW   = 5;
   localparam int D    = 4;
   localparam int QMAX = (1 << QW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          main_arrive = 1'b0, main_left_arrive = 1'b0;
   logic          side_arrive = 1'b0, side_left_arrive = 1'b0;
   logic [2:0]    main_road = 3'b100, side_road = 3'b001;
   logic          main_turn_left = 1'b0, side_turn_left = 1'b0;
   logic          main_sensor, side_sensor;
   logic [QW-1:0] main_q, main_left_q, side_q, side_left_q;
   logic          overflow, fault;
   logic [15:0]   departed_total;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int m_q [4];
   int m_held [4];
   bit m_ovf, m_fault;
   int m_total;

   intersection_traffic_model #(.QUEUE_W(QW), .DEPART_CYCLES(D)) dut (
      .clk(clk), .rst(rst),
      .main_arrive(main_arrive), .main_left_arrive(main_left_arrive),
      .side_arrive(side_arrive), .side_left_arrive(side_left_arrive),
      .main_road(main_road), .side_road(side_road),
      .main_turn_left(main_turn_left), .side_turn_left(side_turn_left),
      .main_sensor(main_sensor), .side_sensor(side_sensor),
      .main_q(main_q), .main_left_q(main_left_q),
      .side_q(side_q), .side_left_q(side_left_q),
      .overflow(overflow), .fault(fault), .departed_total(departed_total)
   );

   always #5 clk = ~clk;

   function automatic bit code_ok(input logic [2:0] c);
      return (c == 3'b100) || (c == 3'b010) || (c == 3'b001);
   endfunction

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_edge();
      bit illegal;
      bit gov [4];
      bit arr [4];
      bit dep;
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            m_q[i] = 0;
            m_held[i] = 0;
         end
         m_ovf = 0; m_fault = 0; m_total = 0;
         return;
      end
      illegal = !code_ok(main_road) || !code_ok(side_road) ||
                (main_road != 3'b100 && side_road != 3'b100) ||
                (main_turn_left && side_turn_left);
      gov[0] = (main_road == 3'b001); gov[1] = main_turn_left;
      gov[2] = (side_road == 3'b001); gov[3] = side_turn_left;
      arr[0] = main_arrive; arr[1] = main_left_arrive;
      arr[2] = side_arrive; arr[3] = side_left_arrive;
      for (int i = 0; i < 4; i++) begin
         dep = 0;
         if (gov[i] && !m_fault && !illegal && m_q[i] > 0) begin
            m_held[i]++;
            if (m_held[i] == D) begin
               dep = 1;
               m_held[i] = 0;
            end
         end else begin
            m_held[i] = 0;
         end
         if (arr[i] && !dep) begin
            if (m_q[i] == QMAX) m_ovf = 1;
            else m_q[i]++;
         end else if (dep && !arr[i]) begin
            m_q[i]--;
         end
         if (dep) m_total = (m_total + 1) % 65536;
      end
      if (illegal) m_fault = 1;
   endtask

   // One clock edge; arrival pulses are cleared afterwards.
   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      main_arrive = 0; main_left_arrive = 0; side_arrive = 0; side_left_arrive = 0;
   endtask

   task automatic set_lights(input logic [2:0] mr, input logic [2:0] sr,
                             input logic ml, input logic sl);
      main_road = mr; side_road = sr; main_turn_left = ml; side_turn_left = sl;
   endtask

   task automatic test_reset();
      set_lights(3'b100, 3'b001, 0, 0);
      rst = 1;
      for (int i = 0; i < 2; i++) begin
         main_arrive = 1; main_left_arrive = 1; side_arrive = 1; side_left_arrive = 1;
         step();
      end
      rst = 0;
      n_checks++;
      if ({main_q, main_left_q, side_q, side_left_q} !== '0) begin
         n_fail++; $display("FAIL reset_queues got %h want 0", {main_q, main_left_q, side_q, side_left_q});
      end
      n_checks++;
      if ({main_sensor, side_sensor, overflow, fault} !== 4'b0) begin
         n_fail++; $display("FAIL reset_flags got %b want 0000", {main_sensor, side_sensor, overflow, fault});
      end
      n_checks++;
      if (departed_total !== 16'd0) begin
         n_fail++; $display("FAIL reset_total got %0d want 0", departed_total);
      end
      $display("test_reset done");
   endtask

   task automatic test_paced_release();
      set_lights(3'b100, 3'b001, 0, 0);
      for (int i = 0; i < 3; i++) begin
         main_arrive = 1; step();
      end
      n_checks++;
      if (main_q !== 5'd3 || main_sensor !== 1'b1) begin
         n_fail++; $display("FAIL paced_fill got q=%0d sensor=%b want q=3 sensor=1", main_q, main_sensor);
      end
      set_lights(3'b001, 3'b100, 0, 0);
      for (int n = 1; n <= 12; n++) begin
         step();
         if (n == 3 || n == 4 || n == 8 || n == 11 || n == 12) begin
            int exp_q;
            exp_q = (n < 4) ? 3 : (n < 8) ? 2 : (n < 12) ? 1 : 0;
            n_checks++;
            if (main_q !== 5'(exp_q) || main_sensor !== (exp_q != 0)) begin
               n_fail++;
               $display("FAIL paced_edge_%0d got q=%0d sensor=%b want q=%0d sensor=%b",
                        n, main_q, main_sensor, exp_q, exp_q != 0);
            end
         end
      end
      n_checks++;
      if (departed_total !== 16'd3) begin
         n_fail++; $display("FAIL paced_total got %0d want 3", departed_total);
      end
      $display("test_paced_release done");
   endtask

   task automatic test_interrupted_green();
      set_lights(3'b100, 3'b001, 0, 0);
      for (int i = 0; i < 2; i++) begin
         main_arrive = 1; step();
      end
      set_lights(3'b001, 3'b100, 0, 0);
      repeat (3) step();
      set_lights(3'b010, 3'b100, 0, 0);
      step();
      n_checks++;
      if (main_q !== 5'd2) begin
         n_fail++; $display("FAIL interrupt_hold got %0d want 2", main_q);
      end
      set_lights(3'b001, 3'b100, 0, 0);
      repeat (3) step();
      n_checks++;
      if (main_q !== 5'd2) begin
         n_fail++; $display("FAIL interrupt_restart_early got %0d want 2", main_q);
      end
      step();
      n_checks++;
      if (main_q !== 5'd1) begin
         n_fail++; $display("FAIL interrupt_restart_depart got %0d want 1", main_q);
      end
      set_lights(3'b100, 3'b001, 0, 0);
      step();
      $display("test_interrupted_green done");
   endtask

   task automatic test_simultaneous();
      logic [15:0] tot0;
      tot0 = departed_total;
      set_lights(3'b001, 3'b100, 0, 0);
      repeat (3) step();
      main_arrive = 1;
      step();
      n_checks++;
      if (main_q !== 5'd1 || departed_total !== tot0 + 16'd1) begin
         n_fail++; $display("FAIL simul_arrive_depart got q=%0d total=%0d want q=1 total=%0d",
                            main_q, departed_total, tot0 + 16'd1);
      end
      set_lights(3'b100, 3'b100, 0, 0);
      for (int i = 0; i < 2; i++) begin
         main_left_arrive = 1; step();
      end
      set_lights(3'b100, 3'b001, 1, 0);
      repeat (4) step();
      n_checks++;
      if (main_left_q !== 5'd1 || main_q !== 5'd1) begin
         n_fail++; $display("FAIL left_first got left=%0d thru=%0d want left=1 thru=1", main_left_q, main_q);
      end
      repeat (4) step();
      n_checks++;
      if (main_left_q !== 5'd0 || main_q !== 5'd1 || main_sensor !== 1'b1) begin
         n_fail++; $display("FAIL left_drain got left=%0d thru=%0d sensor=%b want 0 1 1",
                            main_left_q, main_q, main_sensor);
      end
      set_lights(3'b100, 3'b001, 0, 0);
      $display("test_simultaneous done");
   endtask

   task automatic test_saturation();
      set_lights(3'b100, 3'b100, 0, 0);
      for (int i = 0; i < 33; i++) begin
         side_arrive = 1; step();
      end
      n_checks++;
      if (side_q !== 5'd31 || overflow !== 1'b1 || side_sensor !== 1'b1) begin
         n_fail++; $display("FAIL sat_full got q=%0d ovf=%b sensor=%b want 31 1 1", side_q, overflow, side_sensor);
      end
      set_lights(3'b100, 3'b001, 0, 0);
      repeat (31 * D) step();
      n_checks++;
      if (side_q !== 5'd0 || overflow !== 1'b1) begin
         n_fail++; $display("FAIL sat_drain got q=%0d ovf=%b want 0 1", side_q, overflow);
      end
      $display("test_saturation done");
   endtask

   task automatic test_conflict();
      logic [15:0] tot0;
      set_lights(3'b100, 3'b100, 0, 0);
      for (int i = 0; i < 2; i++) begin
         side_arrive = 1; step();
      end
      // main_q is 1 from earlier scenarios
      tot0 = departed_total;
      set_lights(3'b001, 3'b001, 0, 0);
      step();
      n_checks++;
      if (fault !== 1'b1 || main_q !== 5'd1 || side_q !== 5'd2 || departed_total !== tot0) begin
         n_fail++; $display("FAIL conflict_edge got fault=%b mq=%0d sq=%0d tot=%0d want 1 1 2 %0d",
                            fault, main_q, side_q, departed_total, tot0);
      end
      set_lights(3'b001, 3'b100, 0, 0);
      repeat (2 * D) step();
      main_arrive = 1;
      step();
      n_checks++;
      if (main_q !== 5'd2 || departed_total !== tot0 || fault !== 1'b1) begin
         n_fail++; $display("FAIL conflict_frozen got mq=%0d tot=%0d fault=%b want 2 %0d 1",
                            main_q, departed_total, fault, tot0);
      end
      rst = 1; step(); rst = 0;
      n_checks++;
      if (fault !== 1'b0) begin
         n_fail++; $display("FAIL conflict_rst_clear got %b want 0", fault);
      end
      set_lights(3'b011, 3'b100, 0, 0);
      step();
      n_checks++;
      if (fault !== 1'b1) begin
         n_fail++; $display("FAIL bad_code_fault got %b want 1", fault);
      end
      set_lights(3'b100, 3'b100, 1, 1);
      rst = 1; step(); rst = 0;
      step();
      n_checks++;
      if (fault !== 1'b1) begin
         n_fail++; $display("FAIL both_arrows_fault got %b want 1", fault);
      end
      set_lights(3'b100, 3'b001, 0, 0);
      rst = 1; step(); rst = 0;
      $display("test_conflict done");
   endtask

   task automatic test_random();
      int hold;
      int sel;
      hold = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (hold == 0) begin
            hold = $urandom_range(12, 1);
            sel = $urandom_range(99, 0);
            if      (sel < 20) set_lights(3'b001, 3'b100, $urandom_range(1, 0), 0);
            else if (sel < 40) set_lights(3'b100, 3'b001, 0, $urandom_range(1, 0));
            else if (sel < 50) set_lights(3'b010, 3'b100, 0, 0);
            else if (sel < 60) set_lights(3'b100, 3'b010, 0, 0);
            else if (sel < 75) set_lights(3'b100, 3'b100, 1, 0);
            else if (sel < 90) set_lights(3'b100, 3'b100, 0, 1);
            else if (sel < 97) set_lights(3'b100, 3'b100, 0, 0);
            else               set_lights(3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
         end
         hold--;
         main_arrive      = ($urandom_range(3, 0) == 0);
         main_left_arrive = ($urandom_range(4, 0) == 0);
         side_arrive      = ($urandom_range(3, 0) == 0);
         side_left_arrive = ($urandom_range(4, 0) == 0);
         rst = ($urandom_range(299, 0) == 0);
         step();
         rst = 0;
         n_checks++;
         if (main_q !== 5'(m_q[0]) || main_left_q !== 5'(m_q[1]) ||
             side_q !== 5'(m_q[2]) || side_left_q !== 5'(m_q[3])) begin
            n_fail++;
            $display("FAIL rand_queues cyc=%0d got %0d %0d %0d %0d want %0d %0d %0d %0d", cyc,
                     main_q, main_left_q, side_q, side_left_q, m_q[0], m_q[1], m_q[2], m_q[3]);
         end
         n_checks++;
         if (overflow !== m_ovf || fault !== m_fault || departed_total !== 16'(m_total) ||
             main_sensor !== (m_q[0] != 0 || m_q[1] != 0) ||
             side_sensor !== (m_q[2] != 0 || m_q[3] != 0)) begin
            n_fail++;
            $display("FAIL rand_flags cyc=%0d got ovf=%b fault=%b tot=%0d ms=%b ss=%b want ovf=%b fault=%b tot=%0d",
                     cyc, overflow, fault, departed_total, main_sensor, side_sensor, m_ovf, m_fault, m_total);
         end
      end
      $display("test_random done");
   endtask

   initial begin
      test_reset();
      test_paced_release();
      test_interrupted_green();
      test_simultaneous();
      test_saturation();
      test_conflict();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
